id_stage_pipe: RTL and testbench

Registered, handshaked successor to the combinational ID stage. Decodes RV64I instructions into register-file requests, a sign-extended XLEN immediate, an ALU op code and an illegal flag. Sits between IF and EX with a valid/ready pipeline register plus a one-entry skid buffer, so EX back-pressure never drops an instruction. Adds flush support for branch redirect.

---
 rtl/id_stage_pipe.sv | 268 ++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV64I decode stage with a valid/ready output register and a one-entry skid buffer.
// Latency: an instruction accepted on edge N is visible on out_* right after edge N.
// Backpressure: main register plus skid absorb one stall; in_ready drops only while the skid is occupied.
//
// Ports: clock/reset (async, active-high), flush (synchronous kill of held and incoming bundles),
//   in_valid/in_ready/in_inst/in_pc from IF, out_valid/out_ready plus the decoded bundle to EX:
//   pc, rs1/rs2/rd enables and indices, sign-extended imm, alu_op, word, illegal.
// Build option: define ID_RV64W_EN to decode OP-IMM-32/OP-32 (out_word=1); otherwise they are illegal.
module id_stage_pipe #(
   parameter int XLEN   = 64,
   parameter int INST_W = 32,
   parameter int REG_AW = 5,
   parameter int PC_W   = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_rs1_en,
   output logic              out_rs2_en,
   output logic              out_rd_en,
   output logic [REG_AW-1:0] out_rs1_addr,
   output logic [REG_AW-1:0] out_rs2_addr,
   output logic [REG_AW-1:0] out_rd_addr,
   output logic [XLEN-1:0]   out_imm,
   output logic [3:0]        out_alu_op,
   output logic              out_word,
   output logic              out_illegal
);

   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
`ifdef ID_RV64W_EN
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
`endif

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic              rs1_en;
      logic              rs2_en;
      logic              rd_en;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd_addr;
      logic [XLEN-1:0]   imm;
      logic [3:0]        alu_op;
`ifdef ID_RV64W_EN
      logic              word;
`endif
      logic              illegal;
   } bundle_t;

   // funct3 -> ALU op for the non-inverted (inst[30]=0) encodings
   function automatic logic [3:0] base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            ill;
   bundle_t         dec;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];
   assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b  = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
   assign imm_j  = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   always_comb begin
      dec          = '0;
      ill          = 1'b0;
      dec.pc       = in_pc;
      dec.rs1_addr = in_inst[19:15];
      dec.rs2_addr = in_inst[24:20];
      dec.rd_addr  = in_inst[11:7];
      case (opcode)
         OPC_OP_IMM: begin
            dec.rs1_en = 1'b1;
            dec.rd_en  = 1'b1;
            dec.imm    = imm_i;
            dec.alu_op = base_op(funct3);
            // 6-bit shamt: inst[25] belongs to the shift amount, only inst[31:26] is checked
            if (funct3 == 3'b001) begin
               ill = (in_inst[31:26] != 6'b000000);
            end else if (funct3 == 3'b101) begin
               ill = (in_inst[31:26] != 6'b000000) && (in_inst[31:26] != 6'b010000);
               if (in_inst[30]) dec.alu_op = ALU_SRA;
            end
         end
         OPC_OP: begin
            dec.rs1_en = 1'b1;
            dec.rs2_en = 1'b1;
            dec.rd_en  = 1'b1;
            dec.alu_op = base_op(funct3);
            if (funct7 == 7'b0100000) begin
               if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
               else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
               else                       ill = 1'b1;
            end else if (funct7 != 7'b0000000) begin
               ill = 1'b1;
            end
         end
         OPC_LUI:    begin dec.rd_en = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_PASS; end
         OPC_AUIPC:  begin dec.rd_en = 1'b1; dec.imm = imm_u; end
         OPC_JAL:    begin dec.rd_en = 1'b1; dec.imm = imm_j; end
         OPC_JALR:   begin dec.rs1_en = 1'b1; dec.rd_en = 1'b1; dec.imm = imm_i; end
         OPC_BRANCH: begin dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.imm = imm_b; dec.alu_op = ALU_SUB; end
         OPC_LOAD:   begin dec.rs1_en = 1'b1; dec.rd_en = 1'b1; dec.imm = imm_i; end
         OPC_STORE:  begin dec.rs1_en = 1'b1; dec.rs2_en = 1'b1; dec.imm = imm_s; end
`ifdef ID_RV64W_EN
         OPC_OP_IMM_32: begin
            dec.rs1_en = 1'b1;
            dec.rd_en  = 1'b1;
            dec.imm    = imm_i;
            dec.word   = 1'b1;
            // 5-bit shamt: full funct7 checked, so inst[25]=1 is rejected
            case (funct3)
               3'b000: dec.alu_op = ALU_ADD;
               3'b001: begin dec.alu_op = ALU_SLL; ill = (funct7 != 7'b0000000); end
               3'b101: begin
                  dec.alu_op = in_inst[30] ? ALU_SRA : ALU_SRL;
                  ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
               default: ill = 1'b1;
            endcase
         end
         OPC_OP_32: begin
            dec.rs1_en = 1'b1;
            dec.rs2_en = 1'b1;
            dec.rd_en  = 1'b1;
            dec.word   = 1'b1;
            case (funct3)
               3'b000: begin
                  dec.alu_op = in_inst[30] ? ALU_SUB : ALU_ADD;
                  ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
               3'b001: begin dec.alu_op = ALU_SLL; ill = (funct7 != 7'b0000000); end
               3'b101: begin
                  dec.alu_op = in_inst[30] ? ALU_SRA : ALU_SRL;
                  ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
               default: ill = 1'b1;
            endcase
         end
`endif
         default: ill = 1'b1;
      endcase
      // x0 is never a real destination
      if (dec.rd_addr == '0) dec.rd_en = 1'b0;
      if (ill) begin
         dec.rs1_en = 1'b0;
         dec.rs2_en = 1'b0;
         dec.rd_en  = 1'b0;
         dec.imm    = '0;
         dec.alu_op = ALU_ADD;
`ifdef ID_RV64W_EN
         dec.word   = 1'b0;
`endif
      end
      dec.illegal = ill;
   end

   // Buffering: main register feeds EX, skid catches the one bundle that arrives while EX stalls
   bundle_t main_q, main_d, skid_q, skid_d;
   logic    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic    accept;

   assign in_ready = !skid_vld_q;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || out_ready) begin
         // in_ready is low while the skid is full, so the skid drain never collides with accept
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d     = dec;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid    = main_vld_q;
   assign out_pc       = main_q.pc;
   assign out_rs1_en   = main_q.rs1_en;
   assign out_rs2_en   = main_q.rs2_en;
   assign out_rd_en    = main_q.rd_en;
   assign out_rs1_addr = main_q.rs1_addr;
   assign out_rs2_addr = main_q.rs2_addr;
   assign out_rd_addr  = main_q.rd_addr;
   assign out_imm      = main_q.imm;
   assign out_alu_op   = main_q.alu_op;
   assign out_illegal  = main_q.illegal;
`ifdef ID_RV64W_EN
   assign out_word     = main_q.word;
`else
   assign out_word     = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;
   logic        clock = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, out_pc, out_imm;
   logic        out_rs1_en, out_rs2_en, out_rd_en, out_word, out_illegal;
   logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
   logic [3:0]  out_alu_op;

   always #5 clock = ~clock;

   id_stage_pipe dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_en(out_rd_en),
      .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
      .out_imm(out_imm), .out_alu_op(out_alu_op), .out_word(out_word), .out_illegal(out_illegal)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic        rs1_en, rs2_en, rd_en;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm;
      logic [3:0]  alu;
      logic        word;
      logic        illegal;
   } bun_t;

   localparam int NV = 20;
   logic [31:0] v_inst [NV];
   bun_t        v_exp  [NV];
   bun_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // register indices only matter where the matching enable is set
   function automatic bun_t mk(input logic [63:0] pc, input logic r1e, input logic r2e, input logic rde,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                               input logic [63:0] imm, input logic [3:0] alu, input logic w, input logic il);
      bun_t b;
      b.pc = pc; b.rs1_en = r1e; b.rs2_en = r2e; b.rd_en = rde;
      b.rs1 = r1e ? r1 : 5'd0;
      b.rs2 = r2e ? r2 : 5'd0;
      b.rd  = rde ? rd : 5'd0;
      b.imm = imm; b.alu = alu; b.word = w; b.illegal = il;
      return b;
   endfunction

   function automatic bun_t ill_b(input logic [63:0] pc);
      return mk(pc, 0, 0, 0, 0, 0, 0, 64'd0, 4'd0, 0, 1);
   endfunction

   task automatic cmp_bundle(input bun_t e);
      bun_t a;
      a.pc = out_pc; a.rs1_en = out_rs1_en; a.rs2_en = out_rs2_en; a.rd_en = out_rd_en;
      a.rs1 = e.rs1_en ? out_rs1_addr : 5'd0;
      a.rs2 = e.rs2_en ? out_rs2_addr : 5'd0;
      a.rd  = e.rd_en  ? out_rd_addr  : 5'd0;
      a.imm = out_imm; a.alu = out_alu_op; a.word = out_word; a.illegal = out_illegal;
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL bundle pc=%h: got %h expected %h", e.pc, a, e);
      end
   endtask

   // monitor: whatever sits on the output must be the oldest outstanding expectation
   always @(negedge clock) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected bundle: got pc=%h expected none", out_pc);
         end else begin
            cmp_bundle(exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [31:0] inst, input bun_t e);
      bit ok = 0;
      bit rdy;
      in_valid = 1'b1; in_inst = inst; in_pc = e.pc;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clock); rdy = in_ready;
         @(posedge clock);
         if (rdy && !flush) begin
            exp_q.push_back(e);
            ok = 1;
         end
      end
      #1;
      if (!ok) begin
         total++; bad++;
         $display("FAIL send_timeout: got no accept expected accept pc=%h", e.pc);
      end
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clock);
      @(negedge clock);
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      v_inst[0]  = 32'hFFF00093; v_exp[0]  = mk(0, 1,0,1, 0,0,1,  64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 0, 0); // ADDI x1,x0,-1
      v_inst[1]  = 32'h402081B3; v_exp[1]  = mk(0, 1,1,1, 1,2,3,  64'd0, 4'd1, 0, 0);   // SUB x3,x1,x2
      v_inst[2]  = 32'h42135293; v_exp[2]  = mk(0, 1,0,1, 6,0,5,  64'h421, 4'd7, 0, 0); // SRAI x5,x6,33
      v_inst[3]  = 32'h009433B3; v_exp[3]  = mk(0, 1,1,1, 8,9,7,  64'd0, 4'd4, 0, 0);   // SLTU x7,x8,x9
      v_inst[4]  = 32'h80000537; v_exp[4]  = mk(0, 0,0,1, 0,0,10, 64'hFFFF_FFFF_8000_0000, 4'd10, 0, 0); // LUI
      v_inst[5]  = 32'h12345597; v_exp[5]  = mk(0, 0,0,1, 0,0,11, 64'h1234_5000, 4'd0, 0, 0); // AUIPC
      v_inst[6]  = 32'hFF9FF0EF; v_exp[6]  = mk(0, 0,0,1, 0,0,1,  -64'sd8, 4'd0, 0, 0);  // JAL x1,-8
      v_inst[7]  = 32'h00008067; v_exp[7]  = mk(0, 1,0,0, 1,0,0,  64'd0, 4'd0, 0, 0);   // JALR x0,0(x1)
      v_inst[8]  = 32'hFE208EE3; v_exp[8]  = mk(0, 1,1,0, 1,2,0,  -64'sd4, 4'd1, 0, 0);  // BEQ x1,x2,-4
      v_inst[9]  = 32'h01013603; v_exp[9]  = mk(0, 1,0,1, 2,0,12, 64'd16, 4'd0, 0, 0);  // LD x12,16(x2)
      v_inst[10] = 32'hFE513C23; v_exp[10] = mk(0, 1,1,0, 2,5,0,  -64'sd8, 4'd0, 0, 0);  // SD x5,-8(x2)
      v_inst[11] = 32'h0000007F; v_exp[11] = ill_b(0);                                  // unknown opcode
      v_inst[12] = 32'h023100B3; v_exp[12] = ill_b(0);                                  // funct7=0000001
      v_inst[13] = 32'h003170B3; v_exp[13] = mk(0, 1,1,1, 2,3,1,  64'd0, 4'd9, 0, 0);   // AND x1,x2,x3
      v_inst[14] = 32'h00311113; v_exp[14] = mk(0, 1,0,1, 2,0,2,  64'd3, 4'd2, 0, 0);   // SLLI x2,x2,3
      v_inst[15] = 32'hFFF24213; v_exp[15] = mk(0, 1,0,1, 4,0,4,  64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 0, 0); // XORI
      v_inst[16] = 32'h7FF06313; v_exp[16] = mk(0, 1,0,1, 0,0,6,  64'h7FF, 4'd8, 0, 0); // ORI x6,x0,0x7FF
      v_inst[17] = 32'h003120B3; v_exp[17] = mk(0, 1,1,1, 2,3,1,  64'd0, 4'd3, 0, 0);   // SLT x1,x2,x3
      v_inst[18] = 32'h0010809B;                                                         // ADDIW x1,x1,1
`ifdef ID_RV64W_EN
      v_exp[18] = mk(0, 1,0,1, 1,0,1, 64'd1, 4'd0, 1, 0);
`else
      v_exp[18] = ill_b(0);
`endif
      v_inst[19] = 32'h0010E093; v_exp[19] = mk(0, 1,0,1, 1,0,1,  64'd1, 4'd8, 0, 0);   // ORI x1,x1,1
      for (int i = 0; i < NV; i++) v_exp[i].pc = 64'h1000 + 64'(4 * i);

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_imm",   out_imm,        64'd0);
      check("rst_out_pc",    out_pc,         64'd0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock); #1;

      // single ADDI: visible right after its accept edge
      out_ready = 1'b1;
      send(v_inst[0], v_exp[0]);
      in_valid = 1'b0;
      @(negedge clock);
      check("latency_out_valid", 64'(out_valid), 64'd1);
      drain("drain_single");

      // full table back-to-back with EX always ready
      @(posedge clock); #1;
      for (int i = 0; i < NV; i++) send(v_inst[i], v_exp[i]);
      in_valid = 1'b0;
      drain("drain_stream");

      // back-pressure: two accepted, third held off until EX releases
      @(posedge clock); #1;
      out_ready = 1'b0;
      send(v_inst[1], v_exp[1]);
      send(v_inst[8], v_exp[8]);
      in_valid = 1'b1; in_inst = v_inst[4]; in_pc = v_exp[4].pc;
      @(negedge clock);
      check("full_in_ready", 64'(in_ready), 64'd0);
      @(negedge clock);
      check("full_in_ready_hold", 64'(in_ready), 64'd0);
      @(posedge clock); #1;
      out_ready = 1'b1;
      send(v_inst[4], v_exp[4]);
      in_valid = 1'b0;
      drain("drain_backpressure");

      // flush with main and skid full: both dropped along with the presented input
      @(posedge clock); #1;
      out_ready = 1'b0;
      send(v_inst[2], v_exp[2]);
      send(v_inst[3], v_exp[3]);
      in_valid = 1'b1; in_inst = v_inst[9]; in_pc = v_exp[9].pc; flush = 1'b1;
      @(posedge clock);
      exp_q.delete();
      #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      check("flush_full_out_valid", 64'(out_valid), 64'd0);
      check("flush_full_in_ready",  64'(in_ready),  64'd1);
      @(posedge clock); #1 out_ready = 1'b1;
      repeat (2) @(negedge clock);
      check("flush_full_quiet", 64'(out_valid), 64'd0);

      // flush while the stage could accept: the input is still dropped
      @(posedge clock); #1;
      in_valid = 1'b1; in_inst = v_inst[13]; in_pc = v_exp[13].pc; flush = 1'b1;
      @(negedge clock);
      check("flush_empty_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock); #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      check("flush_empty_drop", 64'(out_valid), 64'd0);

      // asynchronous reset while main and skid hold bundles
      @(posedge clock); #1;
      out_ready = 1'b0;
      send(v_inst[5], v_exp[5]);
      send(v_inst[6], v_exp[6]);
      in_valid = 1'b0;
      @(negedge clock);
      check("pre_rst_in_ready", 64'(in_ready), 64'd0);
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock); #1;
      check("post_rst_in_ready",  64'(in_ready),  64'd1);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      check("post_rst_out_pc",    out_pc,         64'd0);

      // recovery after reset, including the W-op vector
      out_ready = 1'b1;
      send(v_inst[18], v_exp[18]);
      send(v_inst[0], v_exp[0]);
      in_valid = 1'b0;
      drain("drain_final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
